// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, indexes the combinational instruction memory and fills the IF/ID register.
// Optional macro FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module imem_fetch_ctrl #(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP      = PC_WIDTH'(2),
  parameter logic [PC_WIDTH-1:0] MEM_LAST     = PC_WIDTH'(54),
  parameter logic [15:0]         HALT_WORD    = 16'h0000,
  parameter int                  DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [15:0]         instr_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [15:0]         ir,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                ir_valid,
  output logic                busy,
  output logic                halted,
  output logic                fault
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]         perf_fetch_cnt,
  output logic [15:0]         perf_stall_cnt,
  output logic [15:0]         perf_flush_cnt
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] ir_pc_q;
  logic [15:0]         ir_q;
  logic                ir_valid_q;
  logic                fault_q;
  logic [CNT_W-1:0]    drain_q;

  logic [PC_WIDTH-1:0] pc_inc;
  logic                tgt_bad;
  logic                is_halt_word;

  assign pc_inc       = pc_q + PC_STEP;
  assign tgt_bad      = branch_target[0] || (branch_target > MEM_LAST);
  assign is_halt_word = (instr_in == HALT_WORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      drain_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ir_valid_q <= 1'b0;
          if (start) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (branch_taken) begin
            pc_q       <= branch_target;
            ir_valid_q <= 1'b0;
            if (tgt_bad) begin
              fault_q <= 1'b1;
              state_q <= ST_HALT;
            end
          end else if (!stall) begin
            if (is_halt_word) begin
              ir_valid_q <= 1'b0;
              drain_q    <= CNT_W'(DRAIN_CYCLES - 1);
              state_q    <= ST_DRAIN;
            end else begin
              ir_q       <= instr_in;
              ir_pc_q    <= pc_q;
              ir_valid_q <= 1'b1;
              pc_q       <= pc_inc;
              // The word just latched is still delivered; HALT clears ir_valid next edge.
              if (pc_inc > MEM_LAST) begin
                fault_q <= 1'b1;
                state_q <= ST_HALT;
              end
            end
          end
        end
        ST_DRAIN: begin
          ir_valid_q <= 1'b0;
          if (branch_taken) begin
            pc_q <= branch_target;
            if (tgt_bad) begin
              fault_q <= 1'b1;
              state_q <= ST_HALT;
            end else begin
              state_q <= ST_RUN;
            end
          end else if (drain_q == '0) begin
            state_q <= ST_HALT;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        ST_HALT: begin
          ir_valid_q <= 1'b0;
          if (start) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc_out   = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign fault    = fault_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign halted   = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_stall_q;
  logic [15:0] perf_flush_q;
  logic        fetch_evt;
  logic        stall_evt;
  logic        flush_evt;
  logic        start_evt;

  assign fetch_evt = (state_q == ST_RUN) && !branch_taken && !stall && !is_halt_word;
  assign stall_evt = (state_q == ST_RUN) && !branch_taken && stall;
  assign flush_evt = busy && branch_taken;
  assign start_evt = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && start;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else if (start_evt) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (fetch_evt) perf_fetch_q <= sat_inc(perf_fetch_q);
      if (stall_evt) perf_stall_q <= sat_inc(perf_stall_q);
      if (flush_evt) perf_flush_q <= sat_inc(perf_flush_q);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed program scenarios then randomized traffic against a reference model.
module tb_imem_fetch_ctrl;
  localparam int LAST  = 54;
  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start, stall, branch_taken;
  logic [15:0] branch_target, instr_in, pc_out, ir, ir_pc;
  logic        ir_valid, busy, halted, fault;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [0:27];

  always #5 clk = ~clk;

  assign instr_in = (pc_out > 16'd54 || pc_out[0]) ? 16'hDEAD : mem[pc_out[5:1]];

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_in(instr_in), .pc_out(pc_out), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .busy(busy), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Reference model: flags plus a countdown of edges left before halting.
  logic [15:0] m_pc, m_ir, m_irpc;
  bit          m_v, m_fault, m_run, m_halt;
  int          m_drain;
  logic [15:0] m_fc, m_sc, m_flc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_fault = 0;
    m_run = 0; m_halt = 0; m_drain = 0;
    m_fc = 0; m_sc = 0; m_flc = 0;
  endtask

  task automatic m_redirect(input logic [15:0] tgt);
    m_pc = tgt;
    m_v  = 0;
    m_flc = sat(m_flc);
    if (tgt[0] || tgt > LAST) begin
      m_fault = 1; m_run = 0; m_halt = 1;
    end else begin
      m_run = 1;
    end
  endtask

  task automatic m_step(input bit s, input bit st, input bit br, input logic [15:0] tgt);
    logic [15:0] w;
    w = (m_pc > LAST || m_pc[0]) ? 16'hDEAD : mem[m_pc[5:1]];
    if (m_halt) begin
      m_v = 0;
      if (s) begin
        m_pc = 0; m_fault = 0; m_halt = 0; m_run = 1;
        m_fc = 0; m_sc = 0; m_flc = 0;
      end
    end else if (m_drain > 0) begin
      m_v = 0;
      if (br) begin
        m_drain = 0;
        m_redirect(tgt);
      end else begin
        m_drain--;
        if (m_drain == 0) m_halt = 1;
      end
    end else if (m_run) begin
      if (br) begin
        m_redirect(tgt);
      end else if (st) begin
        m_sc = sat(m_sc);
      end else if (w == 16'h0000) begin
        m_v = 0; m_run = 0; m_drain = DRAIN;
      end else begin
        m_ir = w; m_irpc = m_pc; m_v = 1;
        m_fc = sat(m_fc);
        m_pc = m_pc + 16'd2;
        if (m_pc > LAST) begin
          m_fault = 1; m_run = 0; m_halt = 1;
        end
      end
    end else begin
      m_v = 0;
      if (s) begin
        m_run = 1; m_pc = 0;
        m_fc = 0; m_sc = 0; m_flc = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_irpc);
    chk("ir_valid", ir_valid, m_v);
    chk("fault", fault, m_fault);
    chk("halted", halted, m_halt);
    chk("busy", busy, m_run || (m_drain > 0));
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_fc);
    chk("perf_stall", perf_stall_cnt, m_sc);
    chk("perf_flush", perf_flush_cnt, m_flc);
`endif
  endtask

  task automatic cyc(input bit s, input bit st, input bit br, input logic [15:0] tgt);
    start = s; stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    m_step(s, st, br, tgt);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to_pc(input logic [15:0] target);
    for (int i = 0; i < 40 && m_pc != target; i++) cyc(0, 0, 0, 0);
    chk("reach_pc", pc_out, target);
  endtask

  initial begin
    start = 0; stall = 0; branch_taken = 0; branch_target = 0;
    for (int i = 0; i < 28; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'hF120; mem[1] = 16'hF121; mem[2] = 16'h0000;

    #1 reset = 1'b0;
    m_reset();
    #2 check_all();
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0);

    // Short program ending on the terminator word.
    cyc(1, 0, 0, 0);
    chk("no_ir_yet", ir_valid, 1'b0);
    cyc(0, 0, 0, 0);
    chk("first_ir", ir, 16'hF120);
    chk("first_ir_pc", ir_pc, 16'd0);
    cyc(0, 0, 0, 0);
    chk("second_ir", ir, 16'hF121);
    cyc(0, 0, 0, 0);
    chk("halt_word_bubble", ir_valid, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("drain_not_halted", halted, 1'b0);
    cyc(0, 0, 0, 0);
    chk("halted_after_drain", halted, 1'b1);
    chk("no_fault", fault, 1'b0);

    // Stall holds the fetch at pc 10.
    mem[2] = 16'hA002;
    cyc(1, 0, 0, 0);
    run_to_pc(16'd10);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("stall_pc", pc_out, 16'd10);
    end
    cyc(0, 0, 0, 0);
    chk("resume_ir_pc", ir_pc, 16'd10);
    chk("resume_pc", pc_out, 16'd12);

    // Branch beats a simultaneous stall.
    run_to_pc(16'd26);
    cyc(0, 1, 1, 16'd34);
    chk("br_pc", pc_out, 16'd34);
    chk("br_flush", ir_valid, 1'b0);
    cyc(0, 0, 0, 0);
    chk("br_ir", ir, 16'hA011);

    // Bad branch targets fault; start clears.
    cyc(0, 0, 1, 16'd35);
    chk("odd_tgt_fault", fault, 1'b1);
    cyc(0, 1, 1, 16'd4);
    cyc(1, 0, 0, 0);
    chk("restart_pc", pc_out, 16'd0);
    cyc(0, 0, 1, 16'd60);
    chk("far_tgt_fault", fault, 1'b1);
    cyc(1, 0, 0, 0);

    // Straight line off the end of memory.
    for (int i = 0; i < 40 && !m_halt; i++) cyc(0, 0, 0, 0);
    chk("end_ir_pc", ir_pc, 16'd54);
    chk("end_ir_valid", ir_valid, 1'b1);
    chk("end_fault", fault, 1'b1);
    cyc(0, 0, 0, 0);
    chk("end_ir_clear", ir_valid, 1'b0);

    // Asynchronous reset mid-run.
    cyc(1, 0, 0, 0);
    run_to_pc(16'd20);
    #2 reset = 1'b0;
    m_reset();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk("idle_after_reset", pc_out, 16'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("fetch_after_restart", ir_valid, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 28; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
    for (int n = 0; n < 800; n++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 63)) : 16'($urandom_range(0, 29) * 2);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the 16-bit CPU's instruction memory.
- Owns the program counter and drives the word-address index into the combinational-read instruction memory.
- Latches the returned word into the IF/ID instruction register.
- Handles stalls, taken-branch redirects, halt detection on the all-zero terminator word, and out-of-range faults.
- Sits between the instruction memory and the decode stage; hazard and branch units feed it.

Parameters:
- PC_WIDTH, 16, width of the PC and all address ports.
- RESET_PC, 0, PC value loaded on reset and on restart.
- PC_STEP, 2, PC increment per fetched instruction (byte-addressed, 16-bit words).
- MEM_LAST, 54, highest valid fetch address; any fetch above it faults.
- HALT_WORD, 16'h0000, instruction value that terminates the program.
- DRAIN_CYCLES, 3, cycles to wait after halt detection so older instructions retire.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins fetching from RESET_PC
- stall  input  1  hazard unit request to hold fetch
- branch_taken  input  1  execute stage resolved a taken branch this cycle
- branch_target  input  PC_WIDTH  redirect address, valid with branch_taken
- instr_in  input  16  word returned by instruction memory for pc_out
- pc_out  output  PC_WIDTH  current fetch address to instruction memory
- ir  output  16  IF/ID instruction register
- ir_pc  output  PC_WIDTH  address of the instruction held in ir
- ir_valid  output  1  ir holds a real instruction (0 = bubble)
- busy  output  1  state is RUN or DRAIN
- halted  output  1  state is HALT
- fault  output  1  sticky; set on misaligned or out-of-range fetch

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; pc_out=RESET_PC; ir=0; ir_pc=0.
  - ir_valid=0; halted=0; fault=0; drain counter=0.
  - Reset mid-RUN aborts immediately with no partial latch.
- Memory model: read is combinational. instr_in corresponds to the current pc_out, and all captures happen on the rising clk edge.
- IDLE:
  - ir_valid=0; pc_out held.
  - start=1 -> RUN.
  - First ir_valid=1 appears one cycle after the first RUN cycle, i.e. 2 edges after start is sampled.
- RUN, per edge, in priority order:
  1. branch_taken:
     - pc_out=branch_target; ir_valid=0 (flush).
     - Wins over stall and halt detection.
     - If branch_target[0]=1 or branch_target>MEM_LAST: fault=1, state=HALT.
  2. stall: pc_out, ir, ir_pc and ir_valid all held unchanged.
  3. instr_in==HALT_WORD:
     - ir_valid=0; pc_out held.
     - Drain counter=DRAIN_CYCLES-1; state=DRAIN.
  4. Otherwise:
     - ir=instr_in; ir_pc=pc_out; ir_valid=1.
     - pc_out=pc_out+PC_STEP, modulo 2^PC_WIDTH.
     - If the new pc exceeds MEM_LAST: fault=1, state=HALT; the last valid instruction stays latched with ir_valid=1 for one cycle, then clears.
- DRAIN:
  - ir_valid=0.
  - Counter decrements each edge; at 0 -> HALT.
  - branch_taken during DRAIN (older branch resolving): redirect as in RUN and return to RUN.
  - stall is ignored in DRAIN.
- HALT:
  - halted=1; ir_valid=0; pc_out held.
  - start=1 -> pc_out=RESET_PC, fault=0, state=RUN.
  - All other inputs are ignored.
- start while in RUN or DRAIN is ignored.
- busy and halted are decoded combinationally from the state register.
- The state encoding is an implementation choice; the state register must be reset asynchronously.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, three extra outputs are added, each 16-bit, saturating at 16'hFFFF, and cleared by reset and by start:
  - perf_fetch_cnt: increments on each edge that sets ir_valid=1.
  - perf_stall_cnt: increments on each RUN edge where stall=1 and branch_taken=0.
  - perf_flush_cnt: increments on each accepted branch_taken.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, start, memory words F120 @0, F121 @2, 0000 @4 -> ir=F120/ir_pc=0, then F121/2; ir_valid drops at pc=4; halted=1 exactly DRAIN_CYCLES=3 edges after the halt word is seen; fault=0.
- RUN at pc=10, stall=1 for 3 cycles -> pc_out stays 10 and ir/ir_valid are frozen; after release, fetch resumes at 10 and then 12.
- At pc=26, branch_taken=1 with target 34 while stall=1 -> pc_out=34 on the next edge, ir_valid=0 for one cycle, next ir=instr@34.
- branch_taken with target 35 or 60 -> fault=1, halted=1; a following start clears fault and restarts at pc=0.
- Straight-line fetch with no terminator up to pc=54 -> word @54 latched, then fault=1 and HALT.
- Assert reset low mid-RUN at pc=20 -> outputs return to reset values asynchronously; after reset is released, a start is required before fetching resumes.
- With FETCH_PERF_EN defined: 5 fetches, 2 stall cycles, 1 branch -> counters read 5, 2, 1.
